// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling, 8N1 framing.
// Define UART_RX_PARITY_EN to expect an even-parity bit after D7.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 byte_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  rx_meta_q, rx_s_q;
  logic                  par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
  assign par_bad    = par_bad_q;
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          par_bad_d = rx_s_q ^ (^shift_q);
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid stop bit lets an immediately following start bit be caught.
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          ferr_d    = !rx_s_q;
`ifdef UART_RX_PARITY_EN
          perr_d    = par_bad;
`endif
          if (rx_s_q && !par_bad) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level expectation queue checked every cycle, plus literal pins.
module tb_uart_rx;

  localparam int CPB = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       byte_valid, frame_err, parity_err, busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
    int         deadline;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] model_data = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0;
  logic       rst_at_edge = 1'b1;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Compare process: every strobe must match the next expected frame outcome.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      model_data = 8'h00;
      exp_q.delete();
      checks++;
      if (data_out !== 8'h00 || byte_valid !== 1'b0 || frame_err !== 1'b0 ||
          parity_err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got data=%h bv=%b fe=%b pe=%b busy=%b, want all 0",
                 data_out, byte_valid, frame_err, parity_err, busy);
      end
    end else begin
      if (byte_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_ferr++;
      if (parity_err === 1'b1) n_perr++;
      if (byte_valid === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got bv=%b fe=%b pe=%b at cycle %0d, want none",
                   byte_valid, frame_err, parity_err, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({byte_valid, frame_err, parity_err} !== {e.valid, e.ferr, e.perr}) begin
            errors++;
            $display("FAIL strobe_kind: got bv/fe/pe=%b%b%b, want %b%b%b (byte %h)",
                     byte_valid, frame_err, parity_err, e.valid, e.ferr, e.perr, e.data);
          end
          if (e.valid) model_data = e.data;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].deadline) begin
        checks++;
        errors++;
        $display("FAIL strobe_timeout: got no strobe by cycle %0d, want one for byte %h",
                 cyc, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      checks++;
      if (data_out !== model_data) begin
        errors++;
        $display("FAIL data_out: got %h, want %h at cycle %0d", data_out, model_data, cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    exp_t x;
    x.valid    = stop && par_ok;
    x.ferr     = !stop;
    x.perr     = !par_ok;
    x.data     = d;
    x.deadline = cyc + NBITS * CPB + 10;
    exp_q.push_back(x);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^d : ~^d);
`endif
    drive_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic saw_busy;

  initial begin
    // 1: reset one cycle, then idle line
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);
    chk("idle_busy", busy, 0);
    chk("idle_data", data_out, 8'h00);
    chk("idle_strobes", {byte_valid, frame_err, parity_err}, 0);

    // 2: single frame
    send_frame(8'h55, 1'b1, 1'b1);
    idle(10);
    chk("t2_data", data_out, 8'h55);
    chk("t2_nvalid", n_valid, 1);
    chk("t2_nferr", n_ferr, 0);

    // 3: back-to-back frames with no idle gap
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'h2A, 1'b1, 1'b1);
    idle(10);
    chk("t3_data", data_out, 8'h2A);
    chk("t3_nvalid", n_valid, 3);

    // 4: one-cycle glitch aborts in START
    saw_busy = 1'b0;
    rx_in = 1'b0;
    @(posedge clk); #1;
    rx_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b1) saw_busy = 1'b1;
      @(posedge clk); #1;
    end
    chk("t4_saw_busy", saw_busy, 1);
    chk("t4_busy_after", busy, 0);
    chk("t4_nvalid", n_valid, 3);

    // 5: stop bit forced low
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    chk("t5_nferr", n_ferr, 1);
    chk("t5_nvalid", n_valid, 3);
    chk("t5_data_held", data_out, 8'h2A);

    // 6: reset during data bit 4 of 8'hFF, then a clean 8'h3C
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    chk("t6_busy_midframe", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_data_after_rst", data_out, 8'h00);
    chk("t6_nvalid_abort", n_valid, 3);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(10);
    chk("t6_data", data_out, 8'h3C);
    chk("t6_nvalid", n_valid, 4);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(10);
    chk("t6_nperr", n_perr, 1);
    chk("t6_nvalid_par", n_valid, 4);
    chk("t6_data_par", data_out, 8'h3C);
`else
    chk("t6_nperr", n_perr, 0);
`endif

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
